// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: full-speed USB transmit path.
// Takes packet bytes over a valid/ready stream and drives D+/D-. It sends
// SYNC, then the data LSB first with bit stuffing and NRZI, and ends with EOP.
// The 48 MHz clock is divided by CLK_PER_BIT to form the bit time.
// Optional build macro TX_DEBUG_LEDS_EN adds a sticky underrun flag. With it,
// an underrun packet ends with a bit-stuff-violation abort pattern.
module usb_tx_serializer #(
  parameter int CLK_PER_BIT = 4,
  parameter int STUFF_LIMIT = 6
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       dp_out,
  output logic       dn_out,
  output logic       out_en,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       dbg_underrun
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_PER_BIT - 1);
  localparam logic [OW-1:0] ONES_LIMIT = OW'(STUFF_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_ABORT,
    S_EOP_SE0,
    S_EOP_J
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;        // clocks into the current bit time
  logic [6:0]      sr_q;         // bits of the current byte not yet sent
  logic [3:0]      nleft_q;      // bits left in sr_q; reused as SE0/abort counter
  logic [OW-1:0]   ones_q;       // consecutive ones on the NRZI input
  logic            last_q;       // byte in the shifter ends the packet
  logic            dp_q, dn_q, oe_q, busy_q, done_q;

  logic [7:0]      hold_data_q;
  logic            hold_last_q;
  logic            hold_full_q, hold_full_d;

  logic            strobe, stuff_due, at_boundary, load_hold, accept, next_bit;

  // Decode bit-time events and the byte-boundary reload from current state.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    strobe      = (cnt_q == CNT_LAST);
    stuff_due   = (ones_q == ONES_LIMIT);
    at_boundary = strobe && ((state_q == S_SYNC) || (state_q == S_DATA)) &&
                  !stuff_due && (nleft_q == 4'd0);
    load_hold   = at_boundary && ((state_q == S_SYNC) || !last_q) && hold_full_q;
    accept      = tx_valid && tx_ready;
    next_bit    = (nleft_q != 4'd0) ? sr_q[0] : hold_data_q[0];
    hold_full_d = hold_full_q;
    if (load_hold) hold_full_d = 1'b0;
    if (accept)    hold_full_d = 1'b1;
  end

  assign tx_ready = !hold_full_q && (state_q != S_EOP_SE0) && (state_q != S_EOP_J);

  // One-byte holding register between the stream and the shifter.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_q <= 1'b0;
      hold_data_q <= 8'h00;
      hold_last_q <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      if (accept) begin
        hold_data_q <= tx_data;
        hold_last_q <= tx_last;
      end
    end
  end

  // Packet FSM: bit timer, shifter, stuffing, NRZI line and registered pad outputs.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      nleft_q <= '0;
      ones_q  <= '0;
      last_q  <= 1'b0;
      dp_q    <= 1'b1;
      dn_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) cnt_q <= strobe ? '0 : cnt_q + CW'(1);
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (hold_full_q) begin
            // SYNC bit 0 is a 0: the line toggles from J to K at once.
            state_q <= S_SYNC;
            sr_q    <= 7'b1000000;
            nleft_q <= 4'd7;
            ones_q  <= '0;
            dp_q    <= 1'b0;
            dn_q    <= 1'b1;
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_SYNC, S_DATA: if (strobe) begin
          if (stuff_due) begin
            // A stuffed 0 takes this bit time and leaves the shifter alone.
            dp_q   <= ~dp_q;
            dn_q   <= dp_q;
            ones_q <= '0;
          end else if ((nleft_q != 4'd0) || load_hold) begin
            if (load_hold) begin
              state_q <= S_DATA;
              sr_q    <= hold_data_q[7:1];
              nleft_q <= 4'd7;
              last_q  <= hold_last_q;
            end else begin
              sr_q    <= {1'b0, sr_q[6:1]};
              nleft_q <= nleft_q - 4'd1;
            end
            if (next_bit) begin
              ones_q <= ones_q + OW'(1);
            end else begin
              dp_q   <= ~dp_q;
              dn_q   <= dp_q;
              ones_q <= '0;
            end
          end else if ((state_q == S_DATA) && last_q) begin
            state_q <= S_EOP_SE0;
            dp_q    <= 1'b0;
            dn_q    <= 1'b0;
            nleft_q <= '0;
          end else begin
`ifdef TX_DEBUG_LEDS_EN
            // Underrun: hold the line for 7 bits and skip stuffing, so the host sees a violation.
            state_q <= S_ABORT;
            nleft_q <= 4'd6;
`else
            state_q <= S_EOP_SE0;
            dp_q    <= 1'b0;
            dn_q    <= 1'b0;
            nleft_q <= '0;
`endif
          end
        end
        S_ABORT: if (strobe) begin
          if (nleft_q != 4'd0) begin
            nleft_q <= nleft_q - 4'd1;
          end else begin
            state_q <= S_EOP_SE0;
            dp_q    <= 1'b0;
            dn_q    <= 1'b0;
            nleft_q <= '0;
          end
        end
        S_EOP_SE0: if (strobe) begin
          if (nleft_q == 4'd1) begin
            state_q <= S_EOP_J;
            dp_q    <= 1'b1;
            dn_q    <= 1'b0;
          end else begin
            nleft_q <= nleft_q + 4'd1;
          end
        end
        S_EOP_J: if (strobe) begin
          state_q <= S_IDLE;
          oe_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef TX_DEBUG_LEDS_EN
  logic dbg_q;
  logic underrun;

  assign underrun = at_boundary && (state_q == S_DATA) && !last_q && !hold_full_q;

  // Sticky underrun indicator; only rst_n clears it.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) dbg_q <= 1'b0;
    else if (underrun) dbg_q <= 1'b1;
  end

  assign dbg_underrun = dbg_q;
`else
  assign dbg_underrun = 1'b0;
`endif

  assign dp_out  = dp_q;
  assign dn_out  = dn_q;
  assign out_en  = oe_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer. A stream-level model builds the expected line
// from SYNC, the bytes, stuffing and NRZI. Each clock of the line is then
// compared, and the line is also decoded back into bytes.
module tb_usb_tx_serializer;
  localparam int LIMIT = 6;

  logic clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_last, tx_valid, sel6;
  logic       tx_valid4, tx_valid6;
  logic       tx_ready4, dp4, dn4, oe4, busy4, done4, dbg4;
  logic       tx_ready6, dp6, dn6, oe6, busy6, done6, dbg6;
  logic       obs_ready, obs_dp, obs_dn, obs_oe, obs_busy, obs_done;

  assign tx_valid4 = tx_valid & ~sel6;
  assign tx_valid6 = tx_valid & sel6;
  assign obs_ready = sel6 ? tx_ready6 : tx_ready4;
  assign obs_dp    = sel6 ? dp6   : dp4;
  assign obs_dn    = sel6 ? dn6   : dn4;
  assign obs_oe    = sel6 ? oe6   : oe4;
  assign obs_busy  = sel6 ? busy6 : busy4;
  assign obs_done  = sel6 ? done6 : done4;

  usb_tx_serializer #(.CLK_PER_BIT(4), .STUFF_LIMIT(LIMIT)) dut (
    .clk48(clk48), .rst_n(rst_n), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid4), .tx_ready(tx_ready4), .dp_out(dp4), .dn_out(dn4),
    .out_en(oe4), .tx_busy(busy4), .tx_done(done4), .dbg_underrun(dbg4)
  );

  usb_tx_serializer #(.CLK_PER_BIT(6), .STUFF_LIMIT(LIMIT)) dut6 (
    .clk48(clk48), .rst_n(rst_n), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid6), .tx_ready(tx_ready6), .dp_out(dp6), .dn_out(dn6),
    .out_en(oe6), .tx_busy(busy6), .tx_done(done6), .dbg_underrun(dbg6)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] pkt[$];
  int         n_send;
  bit         underrun;
  int         accepted;
  logic [4:0] exp_q[$];   // {dp, dn, oe, busy, done} per clock
  logic [4:0] got_q[$];
  bit         started;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line: one sample before the packet, then each bit symbol held
  // cpb clocks, then the tx_done sample and one idle sample.
  task automatic build_model(input int cpb);
    logic [1:0] syms[$];
    logic       lvl;
    int         ones;
    logic [7:0] b;
    exp_q.delete();
    lvl  = 1'b1;
    ones = 0;
    for (int k = 0; k <= n_send; k++) begin
      b = (k == 0) ? 8'h80 : pkt[k-1];
      for (int i = 0; i < 8; i++) begin
        if (b[i]) ones++;
        else begin lvl = ~lvl; ones = 0; end
        syms.push_back({lvl, ~lvl});
        if (ones == LIMIT) begin
          lvl  = ~lvl;
          ones = 0;
          syms.push_back({lvl, ~lvl});
        end
      end
    end
`ifdef TX_DEBUG_LEDS_EN
    if (underrun) repeat (7) syms.push_back({lvl, ~lvl});
`endif
    syms.push_back(2'b00);
    syms.push_back(2'b00);
    syms.push_back(2'b10);
    exp_q.push_back(5'b10000);
    foreach (syms[i]) repeat (cpb) exp_q.push_back({syms[i], 3'b110});
    exp_q.push_back(5'b10001);
    exp_q.push_back(5'b10000);
  endtask

  // Drive bytes 0..n_send-1 with tx_valid held and record the line from the
  // first handshake edge. A non-negative abort_at stops after that many samples.
  task automatic run_packet(input int cpb, input int abort_at);
    int idx;
    bit pend;
    int guard;
    build_model(cpb);
    got_q.delete();
    idx = 0; pend = 0; started = 0; accepted = 0; guard = 0;
    while (got_q.size() < exp_q.size() && guard < 3000) begin
      @(negedge clk48);
      guard++;
      if (pend) begin idx++; accepted++; pend = 0; end
      if (started) got_q.push_back({obs_dp, obs_dn, obs_oe, obs_busy, obs_done});
      if (abort_at >= 0 && got_q.size() == abort_at) break;
      if (idx < n_send) begin
        tx_valid = 1'b1;
        tx_data  = pkt[idx];
        tx_last  = (idx == pkt.size() - 1);
      end else begin
        tx_valid = 1'b0;
      end
      pend = tx_valid && obs_ready;
      if (pend) started = 1;
    end
    tx_valid = 1'b0;
  endtask

  // Recover the bytes from the recorded line by NRZI decoding and destuffing.
  task automatic decode_check(input int cpb, input string tag);
    logic [1:0] prev, s;
    int         ones, k, pos;
    logic       bits[$];
    logic [7:0] v;
    prev = 2'b10; ones = 0; k = 0;
    pos = 1 + cpb / 2;
    while (pos < got_q.size()) begin
      s = got_q[pos][4:3];
      if (s == 2'b00) break;
      if (ones == LIMIT) begin
        ones = 0;
      end else begin
        bits.push_back(s == prev);
        ones = (s == prev) ? ones + 1 : 0;
      end
      prev = s;
      k++;
      pos = 1 + k * cpb + cpb / 2;
    end
    check({tag, ".dec_len"}, bits.size(), 8 * (n_send + 1));
    if (bits.size() == 8 * (n_send + 1)) begin
      for (int j = 0; j <= n_send; j++) begin
        for (int i = 0; i < 8; i++) v[i] = bits[8*j+i];
        check($sformatf("%s.dec%0d", tag, j), v, (j == 0) ? 8'h80 : pkt[j-1]);
      end
    end
  endtask

  task automatic run_and_check(input int cpb, input string tag);
    logic [4:0] g;
    run_packet(cpb, -1);
    check({tag, ".started"}, started, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 5'bx;
      check($sformatf("%s.line[%0d]", tag, i), g, exp_q[i]);
    end
    check({tag, ".accepted"}, accepted, n_send);
    if (!underrun) decode_check(cpb, tag);
    repeat (3) @(negedge clk48);
  endtask

  initial begin
    logic exp_dbg;
    int   nb;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; sel6 = 1'b0;
    #12;
    check("rst.dp", dp4, 1);
    check("rst.dn", dn4, 0);
    check("rst.oe", oe4, 0);
    check("rst.ready", tx_ready4, 1);
    check("rst.busy", busy4, 0);
    check("rst.done", done4, 0);
    check("rst.dbg", dbg4, 0);
    @(negedge clk48);
    rst_n = 1'b1;
    repeat (2) @(negedge clk48);

    pkt = {8'hFF}; n_send = 1; underrun = 0;
    run_and_check(4, "ff");
    pkt = {8'h00};
    run_and_check(4, "zero");
    pkt = {8'hA5, 8'h3C, 8'h81}; n_send = 3;
    run_and_check(4, "three");
    pkt = {8'hFC}; n_send = 1;
    run_and_check(4, "stuff_end");
    pkt = {8'hFC, 8'h01}; n_send = 2;
    run_and_check(4, "stuff_bnd");

    pkt = {8'h5A, 8'h77}; n_send = 1; underrun = 1;
    run_and_check(4, "underrun");
`ifdef TX_DEBUG_LEDS_EN
    exp_dbg = 1'b1;
`else
    exp_dbg = 1'b0;
`endif
    check("underrun.dbg", dbg4, exp_dbg);
    underrun = 0;

    for (int p = 0; p < 4; p++) begin
      pkt.delete();
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++)
        pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      n_send = nb;
      run_and_check(4, $sformatf("rnd%0d", p));
    end

    // Reset in the middle of the second data byte.
    pkt = {8'h11, 8'h22}; n_send = 2;
    run_packet(4, 70);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.dp", dp4, 1);
    check("midrst.dn", dn4, 0);
    check("midrst.oe", oe4, 0);
    check("midrst.ready", tx_ready4, 1);
    check("midrst.busy", busy4, 0);
    repeat (3) @(negedge clk48);
    rst_n = 1'b1;
    repeat (2) @(negedge clk48);
    pkt = {8'h2D}; n_send = 1;
    run_and_check(4, "after_rst");

    sel6 = 1'b1;
    pkt = {8'h01}; n_send = 1;
    run_and_check(6, "cpb6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/usb_tx_serializer.md
Name: usb_tx_serializer

Overview:
- Full-speed USB transmit path. It is the outbound counterpart of the differential receive front end.
- Accepts packet bytes over a valid/ready stream and sends them on the D+/D- pads at 12 Mbit/s, using the 48 MHz PLL clock as a 4x bit clock.
- Prepends SYNC, then does LSB-first serialisation, bit stuffing and NRZI encoding, and appends EOP.
- Sits between the packet/protocol layer and the bidirectional pad drivers; `out_en` controls pad direction.

Parameters:
- CLK_PER_BIT, 4, clk48 cycles per USB bit time; must be >= 2.
- STUFF_LIMIT, 6, number of consecutive NRZI-input ones after which a 0 is inserted.

Ports:
- clk48  in  1  48 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  packet byte, sent LSB first
- tx_last  in  1  qualifies tx_data as the final byte of the packet
- tx_valid  in  1  tx_data/tx_last valid
- tx_ready  out  1  holding register can accept a byte
- dp_out  out  1  D+ drive value
- dn_out  out  1  D- drive value
- out_en  out  1  pad output enable
- tx_busy  out  1  packet in progress (SYNC through EOP)
- tx_done  out  1  one-cycle pulse after EOP completes
- dbg_underrun  out  1  sticky underrun flag (see Optional Feature)

Behaviour:
- Reset values: dp_out=1, dn_out=0 (J), out_en=0, tx_ready=1, tx_busy=0, tx_done=0, dbg_underrun=0, FSM=IDLE, all counters 0.
- Reset asserted mid-packet: same values immediately (asynchronous); the packet is dropped with no EOP.
- Handshake: a byte is accepted when tx_valid && tx_ready on a rising edge.
  - The one-byte holding register stores tx_data and tx_last.
  - tx_ready = holding empty && state != EOP_SE0/EOP_J.
- Bit timer: counts 0..CLK_PER_BIT-1. It is cleared when a packet starts. A bit strobe fires when the count reaches CLK_PER_BIT-1, and the line value changes on the cycle after each strobe.
- FSM states:
  - IDLE: line at J, out_en=0. An accepted byte moves to SYNC on the next cycle, with out_en=1, tx_busy=1 and the first SYNC bit driven. Latency from handshake to first K is 1 cycle.
  - SYNC: shifts 0x80 LSB first, giving KJKJKJKK on the line. After the 8th bit, loads the holding register into the shifter and goes to DATA.
  - DATA: shifts 8 bits per byte. At each byte boundary:
    - if the current byte had last=1, go to EOP_SE0;
    - else if the holding register is full, load it;
    - else underrun: go to EOP_SE0 and set the underrun flag.
  - EOP_SE0: dp=dn=0 for 2 bit times (8 cycles).
  - EOP_J: J for 1 bit time. Then out_en=0, tx_busy=0, tx_done=1 for one cycle, and go to IDLE.
- NRZI: bit 0 toggles the line (J<->K); bit 1 holds it. The NRZI state starts at J at the start of each packet.
- Bit stuffing:
  - The ones counter is cleared at SYNC start and incremented on each 1 sent, including the final SYNC 1.
  - When it reaches STUFF_LIMIT, the next bit time carries a stuffed 0 (toggle), the shifter is not advanced, and the counter clears.
  - A data 0 also clears the counter.
  - A stuff that is due after the last data bit is sent before EOP_SE0.
- Byte-boundary timing: the next byte is needed by the strobe ending the 8th data bit, or ending a stuffed bit that follows it. The holding register frees at that load, so tx_ready rises 1 cycle later.
- A tx_valid arriving during EOP is not accepted. It is accepted in IDLE and starts a new packet. Two packets are separated by at least 1 cycle of idle J.

Optional Feature:
- Macro: TX_DEBUG_LEDS_EN.
- Defined:
  - dbg_underrun sets on underrun and stays set until rst_n.
  - The underrun packet additionally ends with 7 forced 1s, with stuffing suppressed, before EOP. This is the bit-stuff-violation abort, so the host discards the packet.
- Undefined:
  - dbg_underrun is tied 0.
  - Underrun goes directly to EOP_SE0 with no abort pattern.

Test Plan:
- Single byte 0xFF with tx_last → line K,J,K,J,K,J,K,K, then K×5, then stuffed J, then J×3. That is 17 bit times (68 cycles), then SE0 for 8 cycles, J for 4 cycles, and tx_done pulses at cycle 81 after the handshake. out_en is high for 80 cycles.
- Byte 0x00 with tx_last after SYNC → 8 consecutive toggles starting from K (J,K,J,K,J,K,J,K), with no stuff bit, then EOP.
- Three bytes 0xA5,0x3C,0x81 (last) with tx_valid held high → each byte accepted exactly once, tx_ready low between loads, no gaps between bytes; decoding the line with NRZI and stuff removal reproduces the bytes.
- Two bytes where the second tx_valid is withheld past the boundary → underrun.
  - With TX_DEBUG_LEDS_EN: 7 held bits, then SE0×8 cycles, then J; dbg_underrun=1.
  - Without the macro: immediate EOP; dbg_underrun=0.
- rst_n pulled low during the second data byte → same cycle: dp=1, dn=0, out_en=0, tx_ready=1. After release, a new 0x2D packet sends correct SYNC and data.
- CLK_PER_BIT=6 instance, single 0x01 byte → every line value held exactly 6 cycles, EOP SE0 lasting 12 cycles.
